// File: rtl/pixel_packet_parser_if.sv
// Byte-stream input and frame-packager-facing outputs of pixel_packet_parser.
// Building with PARSER_STATS_EN adds the pkt_count/err_count statistics signals.
interface pixel_packet_parser_if;
  logic        axiiv;
  logic [7:0]  axiid;
  logic        addr_axiov;
  logic [23:0] addr_axiod;
  logic        pixel_axiov;
  logic [7:0]  pixel_axiod;
  logic        pkt_done;
  logic        pkt_err;
`ifdef PARSER_STATS_EN
  logic [15:0] pkt_count;
  logic [15:0] err_count;

  modport master (
    output axiiv, axiid,
    input  addr_axiov, addr_axiod, pixel_axiov, pixel_axiod,
    input  pkt_done, pkt_err, pkt_count, err_count
  );

  modport slave (
    input  axiiv, axiid,
    output addr_axiov, addr_axiod, pixel_axiov, pixel_axiod,
    output pkt_done, pkt_err, pkt_count, err_count
  );
`else
  modport master (
    output axiiv, axiid,
    input  addr_axiov, addr_axiod, pixel_axiov, pixel_axiod,
    input  pkt_done, pkt_err
  );

  modport slave (
    input  axiiv, axiid,
    output addr_axiov, addr_axiod, pixel_axiov, pixel_axiod,
    output pkt_done, pkt_err
  );
`endif
endinterface

// File: rtl/pixel_packet_parser.sv
// Splits each received packet into one 24-bit address beat plus a pixel byte stream
// and reports every packet outcome. Optional statistics counters: PARSER_STATS_EN.
module pixel_packet_parser #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned PIXELS_PER_PKT = 320
) (
  input  logic                  clk,
  input  logic                  rst,
  pixel_packet_parser_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    PIXELS,
    DROP
  } state_t;

  localparam logic [15:0] PIX_FULL = 16'(PIXELS_PER_PKT);

  state_t      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [15:0] pix_cnt_q, pix_cnt_d;
  // Only the first two address bytes need storing; the third joins them on the beat.
  logic [15:0] addr_sr_q, addr_sr_d;

  logic        addr_axiov_q, addr_axiov_d;
  logic [23:0] addr_axiod_q, addr_axiod_d;
  logic        pixel_axiov_q, pixel_axiov_d;
  logic [7:0]  pixel_axiod_q, pixel_axiod_d;
  logic        pkt_done_q, pkt_done_d;
  logic        pkt_err_q, pkt_err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      byte_cnt_q    <= 2'd0;
      pix_cnt_q     <= 16'd0;
      addr_sr_q     <= 16'd0;
      addr_axiov_q  <= 1'b0;
      addr_axiod_q  <= 24'd0;
      pixel_axiov_q <= 1'b0;
      pixel_axiod_q <= 8'd0;
      pkt_done_q    <= 1'b0;
      pkt_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      pix_cnt_q     <= pix_cnt_d;
      addr_sr_q     <= addr_sr_d;
      addr_axiov_q  <= addr_axiov_d;
      addr_axiod_q  <= addr_axiod_d;
      pixel_axiov_q <= pixel_axiov_d;
      pixel_axiod_q <= pixel_axiod_d;
      pkt_done_q    <= pkt_done_d;
      pkt_err_q     <= pkt_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    pix_cnt_d     = pix_cnt_q;
    addr_sr_d     = addr_sr_q;
    addr_axiov_d  = 1'b0;
    addr_axiod_d  = addr_axiod_q;
    pixel_axiov_d = 1'b0;
    pixel_axiod_d = pixel_axiod_q;
    pkt_done_d    = 1'b0;
    pkt_err_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.axiiv) begin
          if (bus.axiid == SYNC_BYTE) begin
            state_d    = ADDR;
            byte_cnt_d = 2'd0;
          end else begin
            state_d   = DROP;
            pkt_err_d = 1'b1;
          end
        end
      end

      ADDR: begin
        if (bus.axiiv) begin
          addr_sr_d  = {addr_sr_q[7:0], bus.axiid};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd2) begin
            state_d      = PIXELS;
            pix_cnt_d    = 16'd0;
            addr_axiov_d = 1'b1;
            addr_axiod_d = {addr_sr_q, bus.axiid};
          end
        end else begin
          state_d   = IDLE;
          pkt_err_d = 1'b1;
        end
      end

      PIXELS: begin
        if (bus.axiiv) begin
          // A byte beyond the full pixel count makes the packet overlength.
          if (pix_cnt_q == PIX_FULL) begin
            state_d   = DROP;
            pkt_err_d = 1'b1;
          end else begin
            pixel_axiov_d = 1'b1;
            pixel_axiod_d = bus.axiid;
            pix_cnt_d     = pix_cnt_q + 16'd1;
          end
        end else begin
          state_d = IDLE;
          if (pix_cnt_q == PIX_FULL) begin
            pkt_done_d = 1'b1;
          end else begin
            pkt_err_d = 1'b1;
          end
        end
      end

      DROP: begin
        if (!bus.axiiv) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.addr_axiov  = addr_axiov_q;
  assign bus.addr_axiod  = addr_axiod_q;
  assign bus.pixel_axiov = pixel_axiov_q;
  assign bus.pixel_axiod = pixel_axiod_q;
  assign bus.pkt_done    = pkt_done_q;
  assign bus.pkt_err     = pkt_err_q;

`ifdef PARSER_STATS_EN
  // Counter 0 tracks completed packets, counter 1 rejected ones; both saturate.
  logic [1:0] stat_evt;
  assign stat_evt = {pkt_err_d, pkt_done_d};

  for (genvar gi = 0; gi < 2; gi++) begin : g_stat
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (stat_evt[gi] && (cnt_q != 16'hFFFF)) begin
        cnt_d = cnt_q + 16'd1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= 16'd0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

  assign bus.pkt_count = g_stat[0].cnt_q;
  assign bus.err_count = g_stat[1].cnt_q;
`endif

endmodule

// File: tb/tb_pixel_packet_parser.sv
// Drives directed and random packets into pixel_packet_parser and compares every
// address beat, pixel beat and outcome pulse (value and cycle) against a packet-level model.
module tb_pixel_packet_parser;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         PPP  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pixel_packet_parser_if bus();

  pixel_packet_parser #(
    .SYNC_BYTE     (SYNC),
    .PIXELS_PER_PKT(PPP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  pkt[$];
  int          stamps[$];
  logic [23:0] exp_addr[$], got_addr[$];
  int          exp_addr_t[$], got_addr_t[$];
  logic [7:0]  exp_pix[$], got_pix[$];
  int          exp_pix_t[$], got_pix_t[$];
  logic [1:0]  exp_out[$], got_out[$];
  int          exp_out_t[$], got_out_t[$];
  int          n_done = 0, n_err = 0;
  int          checks = 0, passes = 0;

  // Outcome code: bit0 = pkt_done, bit1 = pkt_err.
  always @(negedge clk) begin
    if (bus.addr_axiov) begin
      got_addr.push_back(bus.addr_axiod);
      got_addr_t.push_back(cyc);
    end
    if (bus.pixel_axiov) begin
      got_pix.push_back(bus.pixel_axiod);
      got_pix_t.push_back(cyc);
    end
    if (bus.pkt_done || bus.pkt_err) begin
      got_out.push_back({bus.pkt_err, bus.pkt_done});
      got_out_t.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Packet-level reference: what the packager must see for pkt, given when each byte was driven.
  task automatic model(input int te);
    int npix;
    if (pkt[0] != SYNC) begin
      exp_out.push_back(2'b10); exp_out_t.push_back(stamps[0] + 1); n_err++;
    end else if (pkt.size() < 4) begin
      exp_out.push_back(2'b10); exp_out_t.push_back(te + 1); n_err++;
    end else begin
      exp_addr.push_back({pkt[1], pkt[2], pkt[3]});
      exp_addr_t.push_back(stamps[3] + 1);
      npix = pkt.size() - 4;
      for (int k = 0; k < npix && k < PPP; k++) begin
        exp_pix.push_back(pkt[4 + k]);
        exp_pix_t.push_back(stamps[4 + k] + 1);
      end
      if (npix > PPP) begin
        exp_out.push_back(2'b10); exp_out_t.push_back(stamps[4 + PPP] + 1); n_err++;
      end else if (npix == PPP) begin
        exp_out.push_back(2'b01); exp_out_t.push_back(te + 1); n_done++;
      end else begin
        exp_out.push_back(2'b10); exp_out_t.push_back(te + 1); n_err++;
      end
    end
  endtask

  // Drive pkt contiguously, then hold axiiv low for gap cycles.
  task automatic send_pkt(input int gap);
    int te;
    stamps.delete();
    foreach (pkt[i]) begin
      @(negedge clk);
      rst       = 1'b0;
      bus.axiiv = 1'b1;
      bus.axiid = pkt[i];
      stamps.push_back(cyc);
    end
    @(negedge clk);
    rst       = 1'b0;
    bus.axiiv = 1'b0;
    bus.axiid = 8'($urandom);
    te        = cyc;
    repeat (gap - 1) @(negedge clk);
    model(te);
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_flags"}, {bus.addr_axiov, bus.pixel_axiov, bus.pkt_done, bus.pkt_err}, 4'd0);
    check({tag, "_addr"}, bus.addr_axiod, 24'd0);
    check({tag, "_pix"}, bus.pixel_axiod, 8'd0);
  endtask

  initial begin
    int kind;
    int n;
    bus.axiiv = 1'b0;
    bus.axiid = 8'd0;
    rst       = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
`ifdef PARSER_STATS_EN
    check("reset_pkt_count", bus.pkt_count, 16'd0);
    check("reset_err_count", bus.err_count, 16'd0);
`endif

    pkt = '{8'hA5, 8'h01, 8'h23, 8'h45, 8'h10, 8'h11, 8'h12, 8'h13};
    send_pkt(1);
    pkt = '{8'h5A, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hA5};
    send_pkt(1);
    pkt = '{8'hA5, 8'h00, 8'h00, 8'h10, 8'hAA, 8'hBB};
    send_pkt(2);
    pkt = '{8'hA5, 8'h00, 8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send_pkt(1);

    for (int p = 0; p < 60; p++) begin
      kind = int'($urandom_range(0, 4));
      case (kind)
        0:       n = 4 + PPP;
        1:       n = int'($urandom_range(1, 8));
        2:       n = int'($urandom_range(1, 3));
        3:       n = int'($urandom_range(4, 4 + PPP - 1));
        default: n = int'($urandom_range(4 + PPP + 1, 4 + PPP + 3));
      endcase
      pkt.delete();
      for (int i = 0; i < n; i++) pkt.push_back(8'($urandom));
      if (kind == 1) begin
        while (pkt[0] == SYNC) pkt[0] = 8'($urandom);
      end else begin
        pkt[0] = SYNC;
      end
      send_pkt(int'($urandom_range(1, 3)));
    end

    repeat (3) @(negedge clk);
    check("idle_pix_valid", bus.pixel_axiov, 1'b0);
    if (exp_pix.size() > 0) check("pix_hold", bus.pixel_axiod, exp_pix[$]);
    if (exp_addr.size() > 0) check("addr_hold", bus.addr_axiod, exp_addr[$]);
`ifdef PARSER_STATS_EN
    check("pkt_count", bus.pkt_count, n_done[15:0]);
    check("err_count", bus.err_count, n_err[15:0]);
`endif

    // Two back-to-back good packets, then reset lands inside the third packet's address.
    pkt = '{8'hA5, 8'hDE, 8'hAD, 8'h01, 8'h21, 8'h22, 8'h23, 8'h24};
    send_pkt(1);
    pkt = '{8'hA5, 8'hBE, 8'hEF, 8'h02, 8'h31, 8'h32, 8'h33, 8'h34};
    send_pkt(1);
    @(negedge clk); bus.axiiv = 1'b1; bus.axiid = 8'hA5;
    @(negedge clk); bus.axiid = 8'h12;
    @(negedge clk); rst = 1'b1; bus.axiid = 8'h34;
    @(negedge clk); bus.axiid = 8'h56;
    check_idle_zero("midpkt_reset");
`ifdef PARSER_STATS_EN
    check("midpkt_reset_pkt_count", bus.pkt_count, 16'd0);
    check("midpkt_reset_err_count", bus.err_count, 16'd0);
`endif
    n_done = 0;
    n_err  = 0;
    pkt = '{8'h78, 8'h9A, 8'hBC};
    send_pkt(2);
    repeat (3) @(negedge clk);

    check("addr_beats", got_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      check("addr_data", got_addr[i], exp_addr[i]);
      check("addr_time", got_addr_t[i], exp_addr_t[i]);
    end
    check("pix_beats", got_pix.size(), exp_pix.size());
    for (int i = 0; i < exp_pix.size() && i < got_pix.size(); i++) begin
      check("pix_data", got_pix[i], exp_pix[i]);
      check("pix_time", got_pix_t[i], exp_pix_t[i]);
    end
    check("outcomes", got_out.size(), exp_out.size());
    for (int i = 0; i < exp_out.size() && i < got_out.size(); i++) begin
      check("outcome_kind", got_out[i], exp_out[i]);
      check("outcome_time", got_out_t[i], exp_out_t[i]);
    end
`ifdef PARSER_STATS_EN
    check("final_pkt_count", bus.pkt_count, n_done[15:0]);
    check("final_err_count", bus.err_count, n_err[15:0]);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
